// File: rtl/gx4000_pkg.sv
// rtl/gx4000_pkg.sv - shared types and widths for the GX4000 memory arbiter
package gx4000_pkg;

  localparam int MEM_AW = 23;
  localparam int MEM_DW = 8;

  typedef enum logic [1:0] {OWN_LD, OWN_DMA, OWN_CPU} owner_e;

  typedef enum logic [1:0] {IDLE, CMD, WAIT, ACK} arb_state_e;

endpackage

// File: rtl/gx4000_arb_prio.sv
// rtl/gx4000_arb_prio.sv - 3-way priority select (ld > dma > cpu) with CPU starvation override
module gx4000_arb_prio
  import gx4000_pkg::*;
#(
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic       ld_req,
  input  logic       dma_req,
  input  logic       cpu_req,
  input  logic [7:0] cpu_wait,
  output owner_e     owner,
  output logic       grant_valid
);

  logic cpu_starved;

  // >= rather than == so a loader grant landing on the threshold cannot push the CPU past its bound.
  assign cpu_starved = (cpu_wait >= 8'(CPU_MAX_WAIT));

  always_comb begin
    owner       = OWN_LD;
    grant_valid = ld_req | dma_req | cpu_req;
    if (ld_req) begin
      owner = OWN_LD;
    end else if (cpu_req && (cpu_starved || !dma_req)) begin
      owner = OWN_CPU;
    end else if (dma_req) begin
      owner = OWN_DMA;
    end
  end

endmodule

// File: rtl/gx4000_mem_arbiter.sv
// rtl/gx4000_mem_arbiter.sv - sequences loader, DMA and CPU accesses onto the single external memory port
module gx4000_mem_arbiter
  import gx4000_pkg::*;
#(
  parameter int MEM_LAT      = 2,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              ld_req,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [MEM_DW-1:0] ld_wdata,
  output logic              ld_ack,
  input  logic              dma_req,
  input  logic [MEM_AW-1:0] dma_addr,
  output logic              dma_ack,
  output logic [MEM_DW-1:0] dma_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [MEM_AW-1:0] cpu_addr,
  input  logic [MEM_DW-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [MEM_DW-1:0] cpu_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_data,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [MEM_DW-1:0] mem_q
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [MEM_DW-1:0] wdata_q, wdata_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic [7:0]        cpu_wait_q, cpu_wait_d;
  logic [MEM_DW-1:0] dma_rdata_q, dma_rdata_d;
  logic [MEM_DW-1:0] cpu_rdata_q, cpu_rdata_d;

  owner_e            grant_owner;
  logic              grant_valid;

  gx4000_arb_prio #(
    .CPU_MAX_WAIT (CPU_MAX_WAIT)
  ) u_prio (
    .ld_req      (ld_req),
    .dma_req     (dma_req),
    .cpu_req     (cpu_req),
    .cpu_wait    (cpu_wait_q),
    .owner       (grant_owner),
    .grant_valid (grant_valid)
  );

  assign mem_addr  = addr_q;
  assign mem_data  = wdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_rdata = cpu_rdata_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_cnt_d   = lat_cnt_q;
    cpu_wait_d  = cpu_wait_q;
    dma_rdata_d = dma_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    ld_ack      = 1'b0;
    dma_ack     = 1'b0;
    cpu_ack     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && grant_valid) begin
          owner_d = grant_owner;
          state_d = CMD;
          case (grant_owner)
            OWN_LD: begin
              addr_d  = ld_addr;
              wdata_d = ld_wdata;
              we_d    = 1'b1;
            end
            OWN_DMA: begin
              addr_d  = dma_addr;
              wdata_d = '0;
              we_d    = 1'b0;
            end
            default: begin
              addr_d  = cpu_addr;
              wdata_d = cpu_wdata;
              we_d    = cpu_we;
            end
          endcase
          // Counts grants the CPU lost while it was actually asking.
          if (grant_owner == OWN_CPU) begin
            cpu_wait_d = 8'd0;
          end else if (cpu_req && (cpu_wait_q != 8'hFF)) begin
            cpu_wait_d = cpu_wait_q + 8'd1;
          end
        end
      end
      CMD: begin
        mem_wr = we_q;
        mem_rd = !we_q;
        if (we_q) begin
          state_d = ACK;
        end else begin
          state_d   = WAIT;
          lat_cnt_d = 4'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          if (owner_q == OWN_DMA) begin
            dma_rdata_d = mem_q;
          end else begin
            cpu_rdata_d = mem_q;
          end
          state_d = ACK;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      ACK: begin
        case (owner_q)
          OWN_LD:  ld_ack  = 1'b1;
          OWN_DMA: dma_ack = 1'b1;
          default: cpu_ack = 1'b1;
        endcase
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_LD;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_cnt_q   <= 4'd0;
      cpu_wait_q  <= 8'd0;
      dma_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_cnt_q   <= lat_cnt_d;
      cpu_wait_q  <= cpu_wait_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

endmodule

// File: tb/tb_gx4000_mem_arbiter.sv
// tb/tb_gx4000_mem_arbiter.sv - randomized self-checking bench for gx4000_mem_arbiter
module tb_gx4000_mem_arbiter;
  import gx4000_pkg::*;

  localparam int MEM_LAT      = 2;
  localparam int CPU_MAX_WAIT = 4;
  localparam int LD = 0, DMA = 1, CPU = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n, enable;
  logic        ld_req, dma_req, cpu_req, cpu_we;
  logic [22:0] ld_addr, dma_addr, cpu_addr, mem_addr;
  logic [7:0]  ld_wdata, cpu_wdata, dma_rdata, cpu_rdata, mem_data, mem_q;
  logic        ld_ack, dma_ack, cpu_ack, mem_wr, mem_rd;

  always #5 clk_sys = ~clk_sys;

  gx4000_mem_arbiter #(.MEM_LAT(MEM_LAT), .CPU_MAX_WAIT(CPU_MAX_WAIT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_q(mem_q)
  );

  int n_checks = 0, n_fail = 0, cyc = 0;

  // requester drivers
  logic        pend [3];
  logic [22:0] p_addr [3];
  logic [7:0]  p_data [3];
  logic        p_we;
  bit          rand_mode = 0, dma_auto = 0;

  // transaction-level reference model
  int          m_strobe = -1, m_ack = -1, m_free = 0, m_owner = 0, m_wait = 0;
  bit          m_we;
  logic [22:0] m_addr;
  logic [7:0]  m_data, m_rdata;
  logic [7:0]  m_last [3];
  logic [7:0]  model_mem [int];

  // memory environment and event log
  logic [7:0]  env_mem [int];
  int          rd_cnt = 0;
  logic [22:0] rd_a;
  int          ev_rd_cyc = -1, strobes = 0;
  logic [22:0] ev_rd_addr;
  int          ack_cyc [3];
  int          ack_cnt [3];
  logic [22:0] wr_log [$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [22:0] a);
    return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mread(input logic [22:0] a);
    if (model_mem.exists(int'(a))) return model_mem[int'(a)];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] eread(input logic [22:0] a);
    if (env_mem.exists(int'(a))) return env_mem[int'(a)];
    return init_byte(a);
  endfunction

  function automatic logic [22:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 23'($urandom);
    return 23'h010000 + 23'($urandom_range(0, 31));
  endfunction

  task automatic preload(input logic [22:0] a, input logic [7:0] d);
    model_mem[int'(a)] = d;
    env_mem[int'(a)]   = d;
  endtask

  task automatic set_req(input int r, input logic [22:0] a, input logic [7:0] d, input logic we);
    pend[r] = 1'b1; p_addr[r] = a; p_data[r] = d;
    if (r == CPU) p_we = we;
  endtask

  task automatic new_req(input int r);
    set_req(r, rand_addr(), 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic apply();
    if (rand_mode) begin
      if ($urandom_range(0, 15) == 0) enable = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < 3; r++) begin
        if (!pend[r] && $urandom_range(0, 3) == 0) new_req(r);
        else if (pend[r] && $urandom_range(0, 63) == 0) pend[r] = 1'b0;
      end
    end
    if (dma_auto && !pend[DMA]) new_req(DMA);
    ld_req  = pend[LD];  ld_addr  = p_addr[LD];  ld_wdata  = p_data[LD];
    dma_req = pend[DMA]; dma_addr = p_addr[DMA];
    cpu_req = pend[CPU]; cpu_addr = p_addr[CPU]; cpu_wdata = p_data[CPU]; cpu_we = p_we;
  endtask

  task automatic observe();
    logic       e_rd, e_wr;
    logic [2:0] e_ack;
    int         w;
    e_rd  = (cyc == m_strobe) && !m_we;
    e_wr  = (cyc == m_strobe) && m_we;
    e_ack = '0;
    if (e_rd) m_rdata = mread(m_addr);
    if (cyc == m_ack) begin
      e_ack[m_owner] = 1'b1;
      if (!m_we) m_last[m_owner] = m_rdata;
    end
    check_eq("mem_rd", 32'(mem_rd), 32'(e_rd));
    check_eq("mem_wr", 32'(mem_wr), 32'(e_wr));
    if (cyc >= m_strobe && cyc < m_ack && (!m_we || cyc == m_strobe))
      check_eq("mem_addr", 32'(mem_addr), 32'(m_addr));
    if (e_wr) begin
      check_eq("mem_data", 32'(mem_data), 32'(m_data));
      model_mem[int'(m_addr)] = m_data;
    end
    check_eq("ld_ack",    32'(ld_ack),    32'(e_ack[LD]));
    check_eq("dma_ack",   32'(dma_ack),   32'(e_ack[DMA]));
    check_eq("cpu_ack",   32'(cpu_ack),   32'(e_ack[CPU]));
    check_eq("dma_rdata", 32'(dma_rdata), 32'(m_last[DMA]));
    check_eq("cpu_rdata", 32'(cpu_rdata), 32'(m_last[CPU]));
    check_eq("cpu_wait",  32'(dut.cpu_wait_q), 32'(m_wait));

    // grant decision for a request level seen in a free cycle
    if (reset_n && cyc >= m_free && enable && (ld_req || dma_req || cpu_req)) begin
      if (ld_req) w = LD;
      else if (cpu_req && (!dma_req || m_wait >= CPU_MAX_WAIT)) w = CPU;
      else w = DMA;
      m_owner = w;
      m_we    = (w == LD) || (w == CPU && cpu_we);
      m_addr  = (w == LD) ? ld_addr : (w == DMA) ? dma_addr : cpu_addr;
      m_data  = (w == LD) ? ld_wdata : cpu_wdata;
      m_strobe = cyc + 1;
      m_ack    = cyc + 2 + (m_we ? 0 : MEM_LAT);
      m_free   = m_ack + 1;
      if (w == CPU) m_wait = 0;
      else if (cpu_req && m_wait < 255) m_wait++;
    end

    if (mem_wr) begin
      env_mem[int'(mem_addr)] = mem_data;
      wr_log.push_back(mem_addr);
    end
    if (mem_wr || mem_rd) strobes++;
    if (mem_rd) begin
      rd_cnt = MEM_LAT; rd_a = mem_addr; ev_rd_cyc = cyc; ev_rd_addr = mem_addr;
      mem_q = 8'($urandom);
    end else if (rd_cnt > 0) begin
      rd_cnt--;
      mem_q = (rd_cnt == 0) ? eread(rd_a) : 8'($urandom);
    end else begin
      mem_q = 8'($urandom);
    end
    if (ld_ack)  begin pend[LD]  = 1'b0; ack_cnt[LD]++;  ack_cyc[LD]  = cyc; end
    if (dma_ack) begin pend[DMA] = 1'b0; ack_cnt[DMA]++; ack_cyc[DMA] = cyc; end
    if (cpu_ack) begin pend[CPU] = 1'b0; ack_cnt[CPU]++; ack_cyc[CPU] = cyc; end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    observe();
    @(posedge clk_sys);
    #1;
    cyc++;
    apply();
  endtask

  task automatic wait_ack(input int r, input int budget);
    int start;
    start = ack_cnt[r];
    for (int i = 0; i < budget && ack_cnt[r] == start; i++) tick();
    check_eq("ack_arrived", 32'(ack_cnt[r] != start), 32'd1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (pend[LD] || pend[DMA] || pend[CPU] || cyc < m_free); i++) tick();
    check_eq("drained", 32'(pend[LD] || pend[DMA] || pend[CPU] || cyc < m_free), 32'd0);
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    m_strobe = -1; m_ack = -1; m_free = 0; m_wait = 0;
    for (int r = 0; r < 3; r++) begin m_last[r] = 8'h00; pend[r] = 1'b0; end
    rd_cnt = 0;
    apply();
  endtask

  initial begin
    int c0, a0, s0;
    for (int r = 0; r < 3; r++) begin
      pend[r] = 1'b0; p_addr[r] = '0; p_data[r] = '0; m_last[r] = '0; ack_cnt[r] = 0; ack_cyc[r] = -1;
    end
    p_we = 1'b0; enable = 1'b0; mem_q = 8'h00;
    assert_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    enable  = 1'b1;

    // 1: idle after reset
    repeat (100) begin
      tick();
      check_eq("t1_state", 32'(dut.state_q), 32'(IDLE));
      check_eq("t1_mem_addr", 32'(mem_addr), 32'd0);
    end

    // 2: CPU read latency
    preload(23'h004123, 8'hA5);
    set_req(CPU, 23'h004123, 8'h00, 1'b0); apply(); c0 = cyc;
    wait_ack(CPU, 20);
    check_eq("t2_rd_cycle", 32'(ev_rd_cyc - c0), 32'd1);
    check_eq("t2_rd_addr",  32'(ev_rd_addr), 32'h004123);
    check_eq("t2_ack_cycle", 32'(ack_cyc[CPU] - c0), 32'd4);
    check_eq("t2_rdata", 32'(cpu_rdata), 32'hA5);
    tick();

    // 3: loader and CPU write together
    wr_log.delete();
    set_req(LD, 23'h000010, 8'h3C, 1'b1);
    set_req(CPU, 23'h008000, 8'h77, 1'b1); apply(); c0 = cyc;
    wait_ack(CPU, 30);
    check_eq("t3_ld_ack_cycle",  32'(ack_cyc[LD] - c0), 32'd2);
    check_eq("t3_cpu_ack_cycle", 32'(ack_cyc[CPU] - c0), 32'd5);
    check_eq("t3_writes", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() >= 2) begin
      check_eq("t3_first_wr",  32'(wr_log[0]), 32'h000010);
      check_eq("t3_second_wr", 32'(wr_log[1]), 32'h008000);
    end
    check_eq("t3_ld_data", 32'(eread(23'h000010)), 32'h3C);
    tick();

    // 4: CPU starvation bound against continuous DMA
    a0 = ack_cnt[DMA];
    set_req(CPU, 23'h00ABCD, 8'h00, 1'b0);
    dma_auto = 1; apply();
    wait_ack(CPU, 200);
    dma_auto = 0;
    check_eq("t4_dma_acks", 32'(ack_cnt[DMA] - a0), 32'(CPU_MAX_WAIT));
    tick();
    check_eq("t4_cpu_wait", 32'(dut.cpu_wait_q), 32'd0);
    drain(100);

    // 6: enable gating
    enable = 1'b0;
    set_req(CPU, 23'h002222, 8'h00, 1'b0); apply();
    s0 = strobes;
    repeat (20) tick();
    check_eq("t6_no_strobes", 32'(strobes - s0), 32'd0);
    enable = 1'b1; c0 = cyc;
    wait_ack(CPU, 20);
    check_eq("t6_rd_cycle", 32'(ev_rd_cyc - c0), 32'd1);
    tick();

    // 5: reset in the WAIT state of a DMA read
    set_req(DMA, 23'h001234, 8'h00, 1'b0); apply();
    repeat (2) tick();
    check_eq("t5_in_wait", 32'(dut.state_q), 32'(WAIT));
    a0 = ack_cnt[DMA]; s0 = strobes;
    assert_reset();
    repeat (6) tick();
    check_eq("t5_no_ack", 32'(ack_cnt[DMA] - a0), 32'd0);
    check_eq("t5_no_strobes", 32'(strobes - s0), 32'd0);
    reset_n = 1'b1;
    set_req(DMA, 23'h001234, 8'h00, 1'b0); apply();
    wait_ack(DMA, 20);
    check_eq("t5_rdata", 32'(dma_rdata), 32'(mread(23'h001234)));

    // random traffic with a reset in the middle
    rand_mode = 1;
    repeat (1500) tick();
    assert_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (1500) tick();
    rand_mode = 0;
    enable = 1'b1;
    drain(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
